// File: rtl/rs422_uart_receiver.sv
// RS-422 UART receiver: synchronizes the differential pair, decodes the line bit,
// recovers 8N1 frames by oversampling and presents bytes through a valid/ready register.
module rs422_uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rda,
    input  logic                 rdb,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 line_fault,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int FW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [FW-1:0] FAULT_MAX = FW'(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [SYNC_STAGES-1:0] rda_sync, rdb_sync;
    logic                   rda_s, rdb_s, pair_ok, b, b_last, fall;
    logic [FW-1:0]          fault_cnt;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   ferr_n, good_n, frame_good;

    // Synchronizers reset to the idle line levels so release creates no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rda_sync <= '1;
            rdb_sync <= '0;
        end else begin
            rda_sync <= {rda_sync[SYNC_STAGES-2:0], rda};
            rdb_sync <= {rdb_sync[SYNC_STAGES-2:0], rdb};
        end
    end

    assign rda_s   = rda_sync[SYNC_STAGES-1];
    assign rdb_s   = rdb_sync[SYNC_STAGES-1];
    assign pair_ok = rda_s ^ rdb_s;
    assign b       = pair_ok ? rda_s : b_last;
    assign fall    = b_last & ~b;

    // Fault counter saturates at CLKS_PER_BIT, so equality means ">= threshold"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_last    <= 1'b1;
            fault_cnt <= '0;
        end else begin
            b_last <= b;
            if (pair_ok)
                fault_cnt <= '0;
            else if (fault_cnt != FAULT_MAX)
                fault_cnt <= fault_cnt + FW'(1);
        end
    end

    assign line_fault = (fault_cnt == FAULT_MAX);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            framing_err <= 1'b0;
            frame_good  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            framing_err <= ferr_n;
            frame_good  <= good_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        ferr_n  = 1'b0;
        good_n  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !line_fault) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = b ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n   = '0;
                    // LSB-first right shift lands bit idx in position idx after DATA_BITS samples
                    shreg_n = {b, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_LAST)
                        state_n = STOP;
                    else
                        idx_n = idx + IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    good_n  = b;
                    ferr_n  = ~b;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && line_fault) begin
            state_n = IDLE;
            cnt_n   = '0;
            ferr_n  = 1'b1;
            good_n  = 1'b0;
        end
    end

    // shreg stays stable for many cycles after STOP, so it is read one cycle late here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs422_uart_receiver.sv
// Directed bench for rs422_uart_receiver at CLKS_PER_BIT = 16, 8N1, two sync stages.
module tb_rs422_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rda = 1'b1;
    logic       rdb = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overrun_err, line_fault, busy;

    rs422_uart_receiver #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rda        (rda),
        .rdb        (rdb),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .line_fault (line_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    // Activity monitor, sampled on the falling edge
    int         valid_cycles, busy_cycles, ferr_cnt, ovr_cnt;
    int         valid_rise_cyc, ferr_cyc, ovr_cyc, lf_rise_cyc;
    logic       lf_seen, prev_valid, prev_lf;
    logic [7:0] rise_data;

    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (busy) busy_cycles++;
        if (rx_valid && !prev_valid) begin
            valid_rise_cyc = cyc;
            rise_data      = rx_data;
        end
        if (framing_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (overrun_err) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (line_fault && !prev_lf) lf_rise_cyc = cyc;
        if (line_fault) lf_seen = 1'b1;
        prev_valid = rx_valid;
        prev_lf    = line_fault;
    end

    task automatic clear_mon();
        valid_cycles   = 0;
        busy_cycles    = 0;
        ferr_cnt       = 0;
        ovr_cnt        = 0;
        valid_rise_cyc = -1;
        ferr_cyc       = -1;
        ovr_cyc        = -1;
        lf_rise_cyc    = -1;
        lf_seen        = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rda = v;
        rdb = ~v;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(stop_v, 16);
        drive_bit(1'b1, 4);
    endtask

    int c0;

    initial begin
        prev_valid = 1'b0;
        prev_lf    = 1'b0;
        clear_mon();
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", {29'd0, framing_err, overrun_err, line_fault}, 32'd0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);

        // Good frame 0xFD with consumer ready
        clear_mon();
        c0 = cyc;
        send_frame(8'hFD, 1'b1);
        wait_cycles(8);
        check("fd_latency", 32'(valid_rise_cyc - c0), 32'd156);
        check("fd_data", 32'(rise_data), 32'hFD);
        check("fd_valid_cycles", 32'(valid_cycles), 32'd1);
        check("fd_ferr", 32'(ferr_cnt), 32'd0);
        check("fd_ovr", 32'(ovr_cnt), 32'd0);

        // Four-clock low glitch: false start
        clear_mon();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("glitch_busy_cycles", 32'(busy_cycles), 32'd8);
        check("glitch_valid", 32'(valid_cycles), 32'd0);
        check("glitch_errs", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // 0x55 with a bad stop bit, then a clean 0x0F
        clear_mon();
        c0 = cyc;
        send_frame(8'h55, 1'b0);
        wait_cycles(8);
        check("bad_stop_ferr", 32'(ferr_cnt), 32'd1);
        check("bad_stop_ferr_time", 32'(ferr_cyc - c0), 32'd155);
        check("bad_stop_valid", 32'(valid_cycles), 32'd0);
        clear_mon();
        send_frame(8'h0F, 1'b1);
        wait_cycles(8);
        check("0f_data", 32'(rise_data), 32'h0F);
        check("0f_valid_cycles", 32'(valid_cycles), 32'd1);
        check("0f_ferr", 32'(ferr_cnt), 32'd0);

        // Overrun: 0xA5 then 0x3C with consumer stalled
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        c0 = cyc;
        send_frame(8'h3C, 1'b1);
        wait_cycles(8);
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        check("ovr_time", 32'(ovr_cyc - c0), 32'd156);
        check("ovr_held_data", 32'(rx_data), 32'hA5);
        check("ovr_held_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        wait_cycles(2);
        check("ovr_drained_valid", 32'(rx_valid), 32'd0);

        // Line fault in the middle of a frame
        clear_mon();
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        c0 = cyc;
        rda = 1'b1;
        rdb = 1'b1;
        wait_cycles(20);
        drive_bit(1'b1, 40);
        check("lf_seen", 32'(lf_seen), 32'd1);
        check("lf_rise_time", 32'(lf_rise_cyc - c0), 32'd18);
        check("lf_ferr", 32'(ferr_cnt), 32'd1);
        check("lf_ferr_time", 32'(ferr_cyc - c0), 32'd19);
        check("lf_valid", 32'(valid_cycles), 32'd0);
        check("lf_cleared", 32'(line_fault), 32'd0);
        check("lf_idle", 32'(busy), 32'd0);
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h81, 1'b1);
        wait_cycles(4);
        check("81_data", 32'(rx_data), 32'h81);
        check("81_valid", 32'(rx_valid), 32'd1);
        check("81_ferr", 32'(ferr_cnt), 32'd0);

        // Reset during DATA of 0xC3 (bits LSB first 1,1,0,0,0,0,1,1), released during bit 6
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        check("c3_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("c3_rst_valid", 32'(rx_valid), 32'd0);
        check("c3_rst_data", 32'(rx_data), 32'd0);
        check("c3_rst_busy", 32'(busy), 32'd0);
        check("c3_rst_errs", {29'd0, framing_err, overrun_err, line_fault}, 32'd0);
        clear_mon();
        rx_ready = 1'b1;
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 48);
        drive_bit(1'b1, 4);
        rst = 1'b0;
        drive_bit(1'b1, 12);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 20);
        check("c3_tail_valid", 32'(valid_cycles), 32'd0);
        check("c3_tail_busy", 32'(busy_cycles), 32'd0);
        check("c3_tail_ferr", 32'(ferr_cnt), 32'd0);
        clear_mon();
        c0 = cyc;
        send_frame(8'h7E, 1'b1);
        wait_cycles(8);
        check("7e_latency", 32'(valid_rise_cyc - c0), 32'd156);
        check("7e_data", 32'(rise_data), 32'h7E);
        check("7e_valid_cycles", 32'(valid_cycles), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
